// File: rtl/poly_coef_loader.sv
// Input stage of the NTT multiplier: accepts coefficients, reduces them mod q,
// scatters them over four banks with a conflict-free map, then kicks the core.
module poly_coef_loader #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 8,
  parameter int N_LOG      = 10,
  parameter int Q          = 12289
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_start,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  output logic [3:0]            o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_core_start,
  input  logic                  i_core_done,
  output logic                  o_busy,
  output logic                  o_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT} state_t;

  localparam logic [N_LOG-1:0]      LAST_IDX = '1;
  localparam logic [DATA_WIDTH-1:0] Q_W      = DATA_WIDTH'(Q);

  state_t                r_state;
  state_t                w_next;
  logic [N_LOG-1:0]      r_cnt;
  logic                  r_err;
  logic                  r_core_start;
  logic [3:0]            r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                  w_xfer;
  logic                  w_load_go;
  logic                  w_at_last;
  logic [1:0]            w_bank;
  logic [DATA_WIDTH-1:0] w_red;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_xfer    = i_s_valid & (r_state == S_LOAD);
  assign w_load_go = i_load_start & (r_state == S_IDLE);
  assign w_at_last = (r_cnt == LAST_IDX);
  assign w_red     = (i_s_data >= Q_W) ? (i_s_data - Q_W) : i_s_data;
  assign w_addr    = ADDR_WIDTH'(r_cnt >> 2);

  // Base-4 digit sum; the 2-bit accumulator wraps, giving the mod-4 bank index.
  always_comb begin
    w_bank = '0;
    for (int i = 0; i < N_LOG / 2; i++) begin
      w_bank = w_bank + r_cnt[2*i +: 2];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load_go) w_next = S_LOAD;
      S_LOAD:  if (w_xfer && w_at_last) w_next = S_KICK;
      S_KICK:  w_next = S_WAIT;
      S_WAIT:  if (i_core_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // core_start is registered off KICK so it lands one cycle after the final write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_core_start <= (r_state == S_KICK);
      if (w_load_go) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
        if (i_s_last != w_at_last) r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer ? (4'b0001 << w_bank) : 4'b0000;
      if (w_xfer) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_red;
      end
    end
  end

  assign o_s_ready    = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;
  assign o_core_start = r_core_start;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;

endmodule
